// File: rtl/mprjram_pkg.sv
// Shared types and defaults for the user-project BRAM arbiter.
package mprjram_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef enum logic {
    OWN_WB  = 1'b0,
    OWN_ACC = 1'b1
  } owner_t;

  localparam logic [7:0] BASE_HI_DEF = 8'h38;
  localparam int         DELAYS_DEF  = 10;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin grant: on a tie the requester that did not win last
// time gets the grant. last_grant starts at ACC so WB wins the first tie.
module rr_arb2
  import mprjram_pkg::*;
(
  input  logic   clock,
  input  logic   reset,
  input  logic   req_wb,
  input  logic   req_acc,
  input  logic   update,
  input  owner_t update_owner,
  output logic   gnt_valid,
  output owner_t gnt_owner
);

  owner_t last_grant;

  // Remember who was last served so ties alternate.
  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant <= OWN_ACC;
    end else if (update) begin
      last_grant <= update_owner;
    end
  end

  // Combinational pick among the current requests.
  always_comb begin
    gnt_valid = req_wb | req_acc;
    gnt_owner = OWN_WB;
    if (req_wb && req_acc) begin
      gnt_owner = (last_grant == OWN_ACC) ? OWN_WB : OWN_ACC;
    end else if (req_acc) begin
      gnt_owner = OWN_ACC;
    end
  end

endmodule

// File: rtl/mprjram_arbiter.sv
// Shares the single-port mprjram BRAM between the Wishbone slave port and the
// accelerator master port, one access at a time with a fixed read latency.
//
// state | meaning
// IDLE  | sample requests, latch the winner's access
// ISSUE | drive ram_en_o for one cycle, pulse acc_gnt_o for ACC
// WAIT  | count down the BRAM read latency, capture read data at zero
// RESP  | one-cycle wbs_ack_o or acc_rvalid_o, then back to IDLE
module mprjram_arbiter
  import mprjram_pkg::*;
#(
  parameter int          ADDR_W  = 10,
  parameter int          DELAYS  = DELAYS_DEF,
  parameter logic [7:0]  BASE_HI = BASE_HI_DEF
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  input  logic              acc_req_i,
  input  logic              acc_we_i,
  input  logic [ADDR_W-1:0] acc_adr_i,
  input  logic [31:0]       acc_wdat_i,
  output logic              acc_gnt_o,
  output logic              acc_rvalid_o,
  output logic [31:0]       acc_rdat_o,
  output logic              ram_en_o,
  output logic [3:0]        ram_we_o,
  output logic [ADDR_W-1:0] ram_adr_o,
  output logic [31:0]       ram_wdat_o,
  input  logic [31:0]       ram_rdat_i,
  output logic              busy_o
);

  state_t      state;
  owner_t      owner;
  logic        lat_we;
  logic [3:0]  cnt;
  logic        aborted;
  logic        wb_hit;
  logic        arb_valid;
  owner_t      arb_owner;
  logic        unused_adr_bits;

  assign wb_hit = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:24] == BASE_HI);
  assign busy_o = (state != IDLE);

  // Only the word-address field and the base byte take part in decode.
  assign unused_adr_bits = ^{wbs_adr_i[23:ADDR_W+2], wbs_adr_i[1:0]};

  rr_arb2 u_arb (
    .clock        (wb_clk_i),
    .reset        (wb_rst_i),
    .req_wb       (wb_hit),
    .req_acc      (acc_req_i),
    .update       (state == ISSUE),
    .update_owner (owner),
    .gnt_valid    (arb_valid),
    .gnt_owner    (arb_owner)
  );

  // Access sequencer; all outputs are registered. ram_adr_o/ram_wdat_o double
  // as the address/data latch for the access in flight.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state        <= IDLE;
      owner        <= OWN_WB;
      lat_we       <= 1'b0;
      cnt          <= '0;
      aborted      <= 1'b0;
      wbs_ack_o    <= 1'b0;
      wbs_dat_o    <= '0;
      acc_gnt_o    <= 1'b0;
      acc_rvalid_o <= 1'b0;
      acc_rdat_o   <= '0;
      ram_en_o     <= 1'b0;
      ram_we_o     <= '0;
      ram_adr_o    <= '0;
      ram_wdat_o   <= '0;
    end else begin
      ram_en_o     <= 1'b0;
      ram_we_o     <= '0;
      acc_gnt_o    <= 1'b0;
      wbs_ack_o    <= 1'b0;
      acc_rvalid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (arb_valid) begin
            owner    <= arb_owner;
            aborted  <= 1'b0;
            ram_en_o <= 1'b1;
            state    <= ISSUE;
            if (arb_owner == OWN_WB) begin
              lat_we     <= wbs_we_i;
              ram_adr_o  <= wbs_adr_i[ADDR_W+1:2];
              ram_wdat_o <= wbs_dat_i;
              ram_we_o   <= wbs_we_i ? wbs_sel_i : 4'h0;
            end else begin
              lat_we     <= acc_we_i;
              ram_adr_o  <= acc_adr_i;
              ram_wdat_o <= acc_wdat_i;
              ram_we_o   <= acc_we_i ? 4'hF : 4'h0;
              acc_gnt_o  <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (lat_we) begin
            // A dropped cycle suppresses the ack; the write itself already happened.
            wbs_ack_o <= (owner == OWN_WB) & wbs_cyc_i;
            state     <= RESP;
          end else begin
            aborted <= (owner == OWN_WB) & ~wbs_cyc_i;
            cnt     <= 4'(DELAYS - 1);
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (owner == OWN_WB && !wbs_cyc_i) begin
            aborted <= 1'b1;
          end
          if (cnt == 4'd0) begin
            state <= RESP;
            if (owner == OWN_WB) begin
              wbs_dat_o <= ram_rdat_i;
              wbs_ack_o <= wbs_cyc_i & ~aborted;
            end else begin
              acc_rdat_o   <= ram_rdat_i;
              acc_rvalid_o <= 1'b1;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mprjram_arbiter.sv
// Directed bench for mprjram_arbiter: default instance with a BRAM model of
// latency 10, plus a DELAYS=3 instance for the short-latency read.
module tb_mprjram_arbiter;

  logic        clk;
  logic        rst;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, dat;
  logic        ack;
  logic [31:0] rdat_wb;
  logic        acc_req, acc_we;
  logic [9:0]  acc_adr;
  logic [31:0] acc_wdat;
  logic        acc_gnt, acc_rvalid;
  logic [31:0] acc_rdat;
  logic        ram_en;
  logic [3:0]  ram_we;
  logic [9:0]  ram_adr;
  logic [31:0] ram_wdat, ram_rdat;
  logic        busy;

  logic        cyc3, stb3;
  logic        ack3;
  logic [31:0] dat3;
  logic        ram_en3;
  logic [9:0]  ram_adr3;
  logic [31:0] ram_rdat3;
  logic        acc_gnt3_unused, acc_rvalid3_unused, busy3_unused;
  logic [31:0] acc_rdat3_unused, ram_wdat3_unused;
  logic [3:0]  ram_we3_unused;

  logic [31:0] mem [0:1023];
  logic [31:0] pipe [0:9];
  logic [31:0] pipe3 [0:2];

  int n_run = 0;
  int n_fail = 0;
  int cnt_a, cnt_b, cnt_c;

  mprjram_arbiter u_dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(dat), .wbs_ack_o(ack), .wbs_dat_o(rdat_wb),
    .acc_req_i(acc_req), .acc_we_i(acc_we), .acc_adr_i(acc_adr), .acc_wdat_i(acc_wdat),
    .acc_gnt_o(acc_gnt), .acc_rvalid_o(acc_rvalid), .acc_rdat_o(acc_rdat),
    .ram_en_o(ram_en), .ram_we_o(ram_we), .ram_adr_o(ram_adr), .ram_wdat_o(ram_wdat),
    .ram_rdat_i(ram_rdat), .busy_o(busy)
  );

  mprjram_arbiter #(.DELAYS(3)) u_dut3 (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_cyc_i(cyc3), .wbs_stb_i(stb3), .wbs_we_i(1'b0), .wbs_sel_i(4'hF),
    .wbs_adr_i(32'h3800_0010), .wbs_dat_i(32'h0), .wbs_ack_o(ack3), .wbs_dat_o(dat3),
    .acc_req_i(1'b0), .acc_we_i(1'b0), .acc_adr_i(10'h0), .acc_wdat_i(32'h0),
    .acc_gnt_o(acc_gnt3_unused), .acc_rvalid_o(acc_rvalid3_unused), .acc_rdat_o(acc_rdat3_unused),
    .ram_en_o(ram_en3), .ram_we_o(ram_we3_unused), .ram_adr_o(ram_adr3), .ram_wdat_o(ram_wdat3_unused),
    .ram_rdat_i(ram_rdat3), .busy_o(busy3_unused)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BRAM model: byte writes, reads return data DELAYS cycles after ram_en.
  always @(posedge clk) begin
    if (ram_en && ram_we != 4'h0) begin
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) mem[ram_adr][8*b +: 8] <= ram_wdat[8*b +: 8];
    end
    pipe[0] <= (ram_en && ram_we == 4'h0) ? mem[ram_adr] : 32'hBAD0_0BAD;
    for (int k = 1; k < 10; k++) pipe[k] <= pipe[k-1];
    pipe3[0] <= ram_en3 ? (32'hC0DE_0000 | 32'(ram_adr3)) : 32'hBAD0_0BAD;
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign ram_rdat  = pipe[9];
  assign ram_rdat3 = pipe3[2];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wb_drive(input logic c, input logic w, input logic [3:0] s,
                          input logic [31:0] a, input logic [31:0] d);
    cyc = c; stb = c; we = w; sel = s; adr = a; dat = d;
  endtask

  initial begin
    rst = 1'b1; cyc3 = 1'b0; stb3 = 1'b0;
    wb_drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    acc_req = 1'b0; acc_we = 1'b0; acc_adr = '0; acc_wdat = '0;
    step(); step();
    chk("rst_busy", busy, 0);
    chk("rst_en", ram_en, 0);
    chk("rst_ack", ack, 0);
    chk("rst_gnt", acc_gnt, 0);
    rst = 1'b0;
    step();

    // 1: WB write, issue at cycle 1, ack at cycle 2
    wb_drive(1'b1, 1'b1, 4'hF, 32'h3800_0010, 32'hDEAD_BEEF);
    step();
    chk("wr_en", ram_en, 1);
    chk("wr_adr", ram_adr, 4);
    chk("wr_we", ram_we, 4'hF);
    chk("wr_wdat", ram_wdat, 32'hDEAD_BEEF);
    chk("wr_ack_c1", ack, 0);
    step();
    chk("wr_ack_c2", ack, 1);
    wb_drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    step();
    chk("wr_ack_c3", ack, 0);
    chk("wr_busy_c3", busy, 0);

    // 2: WB read, ack exactly at cycle 12
    wb_drive(1'b1, 1'b0, 4'hF, 32'h3800_0010, 32'h0);
    step();
    chk("rd_en", ram_en, 1);
    chk("rd_we", ram_we, 0);
    cnt_a = 0;
    repeat (10) begin step(); cnt_a += int'(ack); end
    chk("rd_early_ack", cnt_a, 0);
    step();
    chk("rd_ack_c12", ack, 1);
    chk("rd_dat", rdat_wb, 32'hDEAD_BEEF);
    wb_drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    step();
    chk("rd_ack_c13", ack, 0);
    chk("rd_dat_hold", rdat_wb, 32'hDEAD_BEEF);

    // 2b: DELAYS=3 read, ack at cycle 5
    cyc3 = 1'b1; stb3 = 1'b1;
    step();
    cnt_a = 0;
    repeat (3) begin step(); cnt_a += int'(ack3); end
    chk("d3_early_ack", cnt_a, 0);
    step();
    chk("d3_ack_c5", ack3, 1);
    chk("d3_dat", dat3, 32'hC0DE_0004);
    cyc3 = 1'b0; stb3 = 1'b0;
    step();

    // 3: simultaneous requests alternate WB, ACC, WB from reset
    rst = 1'b1; step(); rst = 1'b0; step();
    wb_drive(1'b1, 1'b1, 4'hF, 32'h3800_0020, 32'h1111_1111);
    acc_req = 1'b1; acc_we = 1'b0; acc_adr = 10'd8;
    step();
    chk("rr1_acc_gnt", acc_gnt, 0);
    chk("rr1_we", ram_we, 4'hF);
    step();
    chk("rr1_ack", ack, 1);
    wb_drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    acc_req = 1'b0;
    step(); step();
    wb_drive(1'b1, 1'b1, 4'hF, 32'h3800_0024, 32'h2222_2222);
    acc_req = 1'b1;
    step();
    chk("rr2_acc_gnt", acc_gnt, 1);
    chk("rr2_adr", ram_adr, 8);
    chk("rr2_we", ram_we, 0);
    wb_drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    acc_req = 1'b0;
    cnt_a = 0;
    repeat (10) begin step(); cnt_a += int'(acc_rvalid); end
    chk("rr2_early_rvalid", cnt_a, 0);
    step();
    chk("rr2_rvalid", acc_rvalid, 1);
    chk("rr2_rdat", acc_rdat, 32'h1111_1111);
    step();
    wb_drive(1'b1, 1'b1, 4'hF, 32'h3800_0024, 32'h2222_2222);
    acc_req = 1'b1; acc_adr = 10'd9;
    step();
    chk("rr3_acc_gnt", acc_gnt, 0);
    chk("rr3_adr", ram_adr, 9);
    step();
    chk("rr3_ack", ack, 1);
    wb_drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    acc_req = 1'b0;
    step(); step();

    // 4: partial byte write, then a miss outside the BRAM window
    wb_drive(1'b1, 1'b1, 4'b0101, 32'h3800_0020, 32'hAAAA_5555);
    step();
    chk("sel_we", ram_we, 4'b0101);
    step();
    chk("sel_ack", ack, 1);
    wb_drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    step();
    wb_drive(1'b1, 1'b0, 4'hF, 32'h3000_0000, 32'h0);
    cnt_a = 0; cnt_b = 0; cnt_c = 0;
    repeat (5) begin
      step();
      cnt_a += int'(ram_en); cnt_b += int'(ack); cnt_c += int'(busy);
    end
    chk("miss_en", cnt_a, 0);
    chk("miss_ack", cnt_b, 0);
    chk("miss_busy", cnt_c, 0);
    wb_drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    step();

    // 5: reset during the WAIT of an ACC read
    acc_req = 1'b1; acc_we = 1'b0; acc_adr = 10'd8;
    step();
    chk("rst5_gnt", acc_gnt, 1);
    acc_req = 1'b0;
    repeat (3) step();
    chk("rst5_busy_wait", busy, 1);
    rst = 1'b1;
    step();
    chk("rst5_busy", busy, 0);
    chk("rst5_en", ram_en, 0);
    chk("rst5_we", ram_we, 0);
    chk("rst5_adr", ram_adr, 0);
    chk("rst5_wdat", ram_wdat, 0);
    chk("rst5_ack", ack, 0);
    chk("rst5_gnt_lo", acc_gnt, 0);
    chk("rst5_rvalid", acc_rvalid, 0);
    chk("rst5_acc_rdat", acc_rdat, 0);
    chk("rst5_wb_dat", rdat_wb, 0);
    rst = 1'b0;
    cnt_a = 0;
    repeat (15) begin step(); cnt_a += int'(acc_rvalid); end
    chk("rst5_no_rvalid", cnt_a, 0);

    // 6: WB drops cyc during WAIT, then an ACC read is served normally
    wb_drive(1'b1, 1'b0, 4'hF, 32'h3800_0020, 32'h0);
    step();
    chk("ab_en", ram_en, 1);
    step(); step();
    wb_drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    cnt_a = 0;
    repeat (13) begin step(); cnt_a += int'(ack); end
    chk("ab_no_ack", cnt_a, 0);
    chk("ab_idle", busy, 0);
    acc_req = 1'b1; acc_we = 1'b0; acc_adr = 10'd8;
    step();
    chk("ab_acc_gnt", acc_gnt, 1);
    acc_req = 1'b0;
    repeat (10) step();
    step();
    chk("ab_rvalid", acc_rvalid, 1);
    chk("ab_rdat", acc_rdat, 32'h11AA_1155);
    step();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
